// File: rtl/elem_fetch_seq_if.sv
// Reader request/response bus plus the element output stream of elem_fetch_seq.
// master = the sequencer side, slave = reader model and downstream consumer.
interface elem_fetch_seq_if #(
  parameter int ELEMSZ = 288
);
  logic [31:0]       rd_index;
  logic              rd_read;
  logic              rd_iready;
  logic [ELEMSZ-1:0] rd_data;
  logic              rd_ovalid;
  logic [ELEMSZ-1:0] out_data;
  logic [31:0]       out_index;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_index, rd_read,
    input  rd_iready, rd_data, rd_ovalid,
    output out_data, out_index, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_index, rd_read,
    output rd_iready, rd_data, rd_ovalid,
    input  out_data, out_index, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/elem_fetch_seq.sv
// Sweeps an index range through the cached element reader, one request in flight,
// and queues each returned element with its index into a small output FIFO.
module elem_fetch_seq #(
  parameter int ELEMSZ     = 288,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        first_index,
  input  logic [31:0]        count,
  output logic               busy,
  output logic               done,
  elem_fetch_seq_if.master   bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       next_idx;
  logic [31:0]       remaining;
  logic              done_q;
  logic              accept_start;
  logic              issue;
  logic              push;
  logic              pop;

  logic [ELEMSZ-1:0] data_mem [FIFO_DEPTH];
  logic [31:0]       idx_mem  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;

  // done is registered one cycle after DONE, so busy must also cover that cycle
  assign busy = (state != IDLE) || done_q;
  assign done = done_q;

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    issue        = 1'b0;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done_q) begin
          accept_start = 1'b1;
          state_nxt    = (count == 32'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.rd_iready && (fifo_count < FULL)) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.rd_ovalid) begin
          push      = 1'b1;
          state_nxt = (remaining == 32'd1) ? FLUSH : ISSUE;
        end
      end
      FLUSH: begin
        if (fifo_count == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      next_idx  <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DONE);
      if (accept_start) begin
        next_idx  <= first_index;
        remaining <= count;
      end else if (push) begin
        next_idx  <= next_idx + 32'd1;
        remaining <= remaining - 32'd1;
      end
    end
  end

  // next_idx only advances when the response lands, so it doubles as the held request index
  assign bus.rd_read  = issue;
  assign bus.rd_index = next_idx;

  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = bus.out_valid ? data_mem[rd_ptr] : '0;
  assign bus.out_index = bus.out_valid ? idx_mem[rd_ptr]  : '0;
  assign bus.out_last  = bus.out_valid ? last_mem[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.rd_data;
      idx_mem[wr_ptr]  <= next_idx;
      last_mem[wr_ptr] <= (remaining == 32'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue credit should make this unreachable
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      assert (fifo_count != FULL);
    end
  end

endmodule

// File: tb/tb_elem_fetch_seq.sv
// Directed bench for elem_fetch_seq: reader model with programmable latency and
// iready gaps, a pop/issue monitor, and immediate-assertion checks.
module tb_elem_fetch_seq;

  localparam int ELEMSZ = 288;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] first_index;
  logic [31:0] count;
  logic        busy;
  logic        done;

  elem_fetch_seq_if #(.ELEMSZ(ELEMSZ)) bus ();

  elem_fetch_seq #(.ELEMSZ(ELEMSZ), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_index (first_index),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // knobs owned by the stimulus block
  int hit_lat      = 1;
  int iready_delay = 0;
  int stale_req    = 0;

  // monitor state, sampled on the active edge
  int          cycle_cnt   = 0;
  int          issue_cnt   = 0;
  int          extra_reads = 0;
  int          idx_glitch  = 0;
  int          pop_cnt     = 0;
  int          done_cnt    = 0;
  int          busy_cnt    = 0;
  int          done_cycle  = 0;
  logic [31:0] p_idx       = '0;
  bit          outstanding = 1'b0;
  logic [31:0]       got_idx   [128];
  logic [ELEMSZ-1:0] got_data  [128];
  logic              got_last  [128];
  int                pop_cycle [128];

  // reader model state
  int served_cnt;
  int lat_left;
  int iready_wait;
  int stale_done;
  bit in_flight;

  function automatic logic [ELEMSZ-1:0] exp_data(input logic [31:0] i);
    exp_data = ELEMSZ'(i) * ELEMSZ'(17);
  endfunction

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      done_cnt   <= done_cnt + 1;
      done_cycle <= cycle_cnt;
    end
    if (reset) begin
      outstanding <= 1'b0;
    end else begin
      if (outstanding) begin
        if (bus.rd_index !== p_idx) idx_glitch <= idx_glitch + 1;
        if (bus.rd_read) extra_reads <= extra_reads + 1;
        if (bus.rd_ovalid) outstanding <= 1'b0;
      end
      if (bus.rd_read) begin
        issue_cnt   <= issue_cnt + 1;
        p_idx       <= bus.rd_index;
        outstanding <= 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_idx[pop_cnt]   <= bus.out_index;
        got_data[pop_cnt]  <= bus.out_data;
        got_last[pop_cnt]  <= bus.out_last;
        pop_cycle[pop_cnt] <= cycle_cnt;
        pop_cnt            <= pop_cnt + 1;
      end
    end
  end

  // Reader: answers each accepted request after hit_lat cycles, then holds
  // iready low for iready_delay cycles.
  initial begin
    bus.rd_ovalid = 1'b0;
    bus.rd_iready = 1'b0;
    bus.rd_data   = '0;
    served_cnt    = 0;
    lat_left      = 0;
    iready_wait   = 0;
    stale_done    = 0;
    in_flight     = 1'b0;
    forever begin
      @(negedge clk);
      bus.rd_ovalid = 1'b0;
      if (reset) begin
        served_cnt = issue_cnt;
        in_flight  = 1'b0;
      end else if (stale_done != stale_req) begin
        bus.rd_ovalid = 1'b1;
        bus.rd_data   = ELEMSZ'(32'hDEAD_BEEF);
        stale_done++;
      end else if (served_cnt != issue_cnt) begin
        if (!in_flight) begin
          in_flight = 1'b1;
          lat_left  = hit_lat;
        end
        if (lat_left <= 1) begin
          bus.rd_ovalid = 1'b1;
          bus.rd_data   = exp_data(p_idx);
          served_cnt++;
          in_flight   = 1'b0;
          iready_wait = iready_delay;
        end else begin
          lat_left--;
        end
      end
      if (served_cnt == issue_cnt && iready_wait == 0) begin
        bus.rd_iready = 1'b1;
      end else begin
        bus.rd_iready = 1'b0;
        if (served_cnt == issue_cnt) iready_wait--;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [ELEMSZ-1:0] obs,
                             input logic [ELEMSZ-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checkOutput(tag, ELEMSZ'(obs), ELEMSZ'(exp));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"},      ELEMSZ'(busy),          '0);
    checkOutput({tag, " done"},      ELEMSZ'(done),          '0);
    checkOutput({tag, " rd_read"},   ELEMSZ'(bus.rd_read),   '0);
    checkOutput({tag, " rd_index"},  ELEMSZ'(bus.rd_index),  '0);
    checkOutput({tag, " out_valid"}, ELEMSZ'(bus.out_valid), '0);
    checkOutput({tag, " out_last"},  ELEMSZ'(bus.out_last),  '0);
    checkOutput({tag, " out_index"}, ELEMSZ'(bus.out_index), '0);
    checkOutput({tag, " out_data"},  bus.out_data,           '0);
  endtask

  task automatic applyStimulus(input logic [31:0] fi, input logic [31:0] cnt,
                               output int drive_cycle);
    @(negedge clk);
    drive_cycle = cycle_cnt;
    first_index = fi;
    count       = cnt;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkInt({tag, " done seen"}, done_cnt - d0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int base, r0, d0, b0, g0, e0, st;
    reset         = 1'b1;
    start         = 1'b0;
    first_index   = '0;
    count         = '0;
    bus.out_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    checkResetValues("reset");

    // basic sweep 5..7 on cache hits
    bus.out_ready = 1'b1;
    base = pop_cnt; r0 = issue_cnt; d0 = done_cnt;
    applyStimulus(32'd5, 32'd3, st);
    checkOutput("t1 busy after start", ELEMSZ'(busy), ELEMSZ'(1));
    waitDone("t1", d0, 200);
    idle(5);
    checkInt("t1 pops", pop_cnt - base, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t1 idx%0d", i), ELEMSZ'(got_idx[base+i]), ELEMSZ'(5 + i));
      checkOutput($sformatf("t1 last%0d", i), ELEMSZ'(got_last[base+i]), ELEMSZ'(i == 2));
    end
    checkOutput("t1 data0", got_data[base],   ELEMSZ'(32'h55));
    checkOutput("t1 data1", got_data[base+1], ELEMSZ'(32'h66));
    checkOutput("t1 data2", got_data[base+2], ELEMSZ'(32'h77));
    checkInt("t1 rd_read pulses", issue_cnt - r0, 3);
    checkInt("t1 done once", done_cnt - d0, 1);
    checkInt("t1 done after last pop", int'(done_cycle > pop_cycle[base+2]), 1);
    checkOutput("t1 busy idle", ELEMSZ'(busy), '0);

    // empty sweep
    r0 = issue_cnt; d0 = done_cnt; b0 = busy_cnt;
    applyStimulus(32'd9, 32'd0, st);
    idle(6);
    checkInt("t2 rd_read pulses", issue_cnt - r0, 0);
    checkInt("t2 busy cycles", busy_cnt - b0, 2);
    checkInt("t2 done once", done_cnt - d0, 1);
    checkInt("t2 done timing", done_cycle - st, 2);

    // backpressure: only DEPTH requests may go out while the consumer stalls
    bus.out_ready = 1'b0;
    base = pop_cnt; r0 = issue_cnt; d0 = done_cnt;
    applyStimulus(32'd100, 32'd8, st);
    idle(40);
    checkInt("t3 reads while stalled", issue_cnt - r0, 4);
    checkInt("t3 pops while stalled", pop_cnt - base, 0);
    checkOutput("t3 out_valid stalled", ELEMSZ'(bus.out_valid), ELEMSZ'(1));
    bus.out_ready = 1'b1;
    waitDone("t3", d0, 300);
    checkInt("t3 pops", pop_cnt - base, 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3 idx%0d", i), ELEMSZ'(got_idx[base+i]), ELEMSZ'(100 + i));
      checkOutput($sformatf("t3 last%0d", i), ELEMSZ'(got_last[base+i]), ELEMSZ'(i == 7));
    end
    checkOutput("t3 data5", got_data[base+5], ELEMSZ'(32'd105 * 32'd17));

    // long misses with iready gaps
    hit_lat = 30; iready_delay = 5;
    base = pop_cnt; r0 = issue_cnt; d0 = done_cnt; g0 = idx_glitch; e0 = extra_reads;
    applyStimulus(32'd20, 32'd3, st);
    waitDone("t4", d0, 500);
    checkInt("t4 rd_read pulses", issue_cnt - r0, 3);
    checkInt("t4 rd_index stable", idx_glitch - g0, 0);
    checkInt("t4 extra reads", extra_reads - e0, 0);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("t4 idx%0d", i), ELEMSZ'(got_idx[base+i]), ELEMSZ'(20 + i));
    checkOutput("t4 data2", got_data[base+2], ELEMSZ'(32'd22 * 32'd17));
    hit_lat = 1; iready_delay = 0;
    idle(8);

    // index wrap
    base = pop_cnt; d0 = done_cnt;
    applyStimulus(32'hFFFF_FFFE, 32'd3, st);
    waitDone("t5", d0, 200);
    checkOutput("t5 idx0", ELEMSZ'(got_idx[base]),   ELEMSZ'(32'hFFFF_FFFE));
    checkOutput("t5 idx1", ELEMSZ'(got_idx[base+1]), ELEMSZ'(32'hFFFF_FFFF));
    checkOutput("t5 idx2", ELEMSZ'(got_idx[base+2]), ELEMSZ'(32'h0000_0000));
    checkOutput("t5 last1", ELEMSZ'(got_last[base+1]), '0);
    checkOutput("t5 last2", ELEMSZ'(got_last[base+2]), ELEMSZ'(1));
    idle(4);

    // reset in the middle of element 2's wait, then a stale response
    bus.out_ready = 1'b0;
    hit_lat = 10;
    r0 = issue_cnt;
    applyStimulus(32'd50, 32'd5, st);
    begin
      int n = 0;
      while (issue_cnt - r0 < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    checkInt("t6 second issue", issue_cnt - r0, 2);
    idle(3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    stale_req++;
    idle(3);
    checkResetValues("t6 after reset");
    bus.out_ready = 1'b1;
    hit_lat = 1;
    base = pop_cnt; d0 = done_cnt;
    applyStimulus(32'd0, 32'd1, st);
    waitDone("t6 restart", d0, 200);
    idle(3);
    checkInt("t6 pops", pop_cnt - base, 1);
    checkOutput("t6 idx", ELEMSZ'(got_idx[base]), '0);
    checkOutput("t6 data", got_data[base], '0);
    checkOutput("t6 last", ELEMSZ'(got_last[base]), ELEMSZ'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
